// File: rtl/image_rom_pkg.sv
// Shared types and constants for the image ROM arbiter: widths, requester id,
// arbiter state encoding and the per-beat tag that travels alongside the ROM read.
package image_rom_pkg;

  localparam int ADDR_W     = 11;  // ad[10] selects the upper pROM
  localparam int DATA_W     = 16;
  localparam int LEN_W      = 4;   // burst is len+1 words
  localparam int RD_LATENCY = 2;   // pipelined pROM read latency

  typedef logic req_id_t;

  localparam req_id_t REQ0 = 1'b0;
  localparam req_id_t REQ1 = 1'b1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic    valid;
    req_id_t id;
    logic    last;
  } rom_tag_t;

  // Round-robin pick: on contention the requester not served last wins,
  // otherwise whichever one is asking.
  function automatic req_id_t rr_pick(input logic v0, input logic v1,
                                      input req_id_t last_grant);
    req_id_t pick;
    if (v0 && v1) begin
      pick = ~last_grant;
    end else if (v1) begin
      pick = REQ1;
    end else begin
      pick = REQ0;
    end
    return pick;
  endfunction

endpackage

// File: rtl/rom_tag_pipe.sv
// Delay line for beat tags so that each tag emerges together with the ROM word
// it describes. Cleared asynchronously so an aborted burst leaves no stale tags.
module rom_tag_pipe
  import image_rom_pkg::*;
#(
  parameter int DEPTH = RD_LATENCY
) (
  input  logic     clk,
  input  logic     reset,
  input  rom_tag_t tag_in,
  output rom_tag_t tag_out,
  output logic     any_valid
);

  rom_tag_t [DEPTH-1:0] stage_reg;
  logic     [DEPTH-1:0] stage_valid;

  // Shift tags one stage per clock; reset discards everything in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage_reg <= '0;
    end else begin
      stage_reg[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) begin
        stage_reg[i] <= stage_reg[i-1];
      end
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_valid
    assign stage_valid[gi] = stage_reg[gi].valid;
  end

  assign tag_out   = stage_reg[DEPTH-1];
  assign any_valid = |stage_valid;

endmodule

// File: rtl/image_rom_arbiter.sv
// Two-requester burst arbiter in front of a single pipelined image ROM.
// Whole bursts are granted round-robin, the ROM address is stepped one word
// per clock, and returning words are steered to the owner using tags that
// travel through a latency-matched delay line.
module image_rom_arbiter
  import image_rom_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [LEN_W-1:0]  req0_len,
  output logic              rsp0_valid,
  output logic              rsp0_last,
  output logic [DATA_W-1:0] rsp0_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [LEN_W-1:0]  req1_len,
  output logic              rsp1_valid,
  output logic              rsp1_last,
  output logic [DATA_W-1:0] rsp1_data,
  output logic [ADDR_W-1:0] rom_ad,
  input  logic [DATA_W-1:0] rom_data,
  output logic              busy
);

  arb_state_t        state_reg;
  logic [ADDR_W-1:0] addr_cnt_reg;
  logic [LEN_W-1:0]  beat_cnt_reg;
  req_id_t           owner_reg;
  req_id_t           last_grant_reg;
  rom_tag_t          issue_tag_reg;
  rom_tag_t          tag_out;
  logic              pipe_busy;
  logic              any_req;
  req_id_t           grant_id;

  // Grant decision, only acted upon in IDLE.
  always_comb begin
    any_req  = req0_valid | req1_valid;
    grant_id = rr_pick(req0_valid, req1_valid, last_grant_reg);
  end

  // Arbiter FSM: accept a command in IDLE, then issue one ROM address per clock.
  // The issue tag is registered alongside rom_ad so both leave on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      addr_cnt_reg   <= '0;
      beat_cnt_reg   <= '0;
      owner_reg      <= REQ0;
      last_grant_reg <= REQ1;  // so requester 0 wins the first contention
      issue_tag_reg  <= '0;
      req0_ready     <= 1'b0;
      req1_ready     <= 1'b0;
      rom_ad         <= '0;
    end else begin
      req0_ready    <= 1'b0;
      req1_ready    <= 1'b0;
      issue_tag_reg <= '0;
      case (state_reg)
        ST_IDLE: begin
          if (any_req) begin
            state_reg      <= ST_BURST;
            owner_reg      <= grant_id;
            last_grant_reg <= grant_id;
            if (grant_id == REQ1) begin
              addr_cnt_reg <= req1_addr;
              beat_cnt_reg <= req1_len;
              req1_ready   <= 1'b1;
            end else begin
              addr_cnt_reg <= req0_addr;
              beat_cnt_reg <= req0_len;
              req0_ready   <= 1'b1;
            end
          end
        end
        ST_BURST: begin
          rom_ad        <= addr_cnt_reg;
          issue_tag_reg <= '{valid: 1'b1, id: owner_reg, last: (beat_cnt_reg == '0)};
          addr_cnt_reg  <= addr_cnt_reg + ADDR_W'(1);  // wraps at the top of the ROM
          beat_cnt_reg  <= beat_cnt_reg - LEN_W'(1);
          if (beat_cnt_reg == '0) begin
            state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  rom_tag_pipe #(
    .DEPTH(RD_LATENCY)
  ) u_tag_pipe (
    .clk      (clk),
    .reset    (reset),
    .tag_in   (issue_tag_reg),
    .tag_out  (tag_out),
    .any_valid(pipe_busy)
  );

  // Register the ROM word toward its owner; data holds between that owner's beats.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp0_valid <= 1'b0;
      rsp0_last  <= 1'b0;
      rsp0_data  <= '0;
      rsp1_valid <= 1'b0;
      rsp1_last  <= 1'b0;
      rsp1_data  <= '0;
    end else begin
      rsp0_valid <= tag_out.valid && (tag_out.id == REQ0);
      rsp0_last  <= tag_out.valid && (tag_out.id == REQ0) && tag_out.last;
      rsp1_valid <= tag_out.valid && (tag_out.id == REQ1);
      rsp1_last  <= tag_out.valid && (tag_out.id == REQ1) && tag_out.last;
      if (tag_out.valid && (tag_out.id == REQ0)) begin
        rsp0_data <= rom_data;
      end
      if (tag_out.valid && (tag_out.id == REQ1)) begin
        rsp1_data <= rom_data;
      end
    end
  end

  assign busy = (state_reg == ST_BURST) || issue_tag_reg.valid || pipe_busy;

endmodule

// File: tb/tb_image_rom_arbiter.sv
// Bench for image_rom_arbiter: a pipelined ROM model, two command queues and a
// transaction-level reference that predicts grants, addresses and response beats.
module tb_image_rom_arbiter;
  import image_rom_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic              req0_valid, req0_ready, req1_valid, req1_ready;
  logic [ADDR_W-1:0] req0_addr, req1_addr, rom_ad;
  logic [LEN_W-1:0]  req0_len, req1_len;
  logic              rsp0_valid, rsp0_last, rsp1_valid, rsp1_last, busy;
  logic [DATA_W-1:0] rsp0_data, rsp1_data, rom_data;

  always #5 clk = ~clk;

  image_rom_arbiter dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr), .req0_len(req0_len),
    .rsp0_valid(rsp0_valid), .rsp0_last(rsp0_last), .rsp0_data(rsp0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr), .req1_len(req1_len),
    .rsp1_valid(rsp1_valid), .rsp1_last(rsp1_last), .rsp1_data(rsp1_data),
    .rom_ad(rom_ad), .rom_data(rom_data), .busy(busy)
  );

  // Pipelined ROM: address sampled at an edge, word visible two edges later.
  logic [DATA_W-1:0] rom_mem [2048];
  logic [DATA_W-1:0] rom_r1;
  always @(posedge clk) begin
    rom_r1   <= rom_mem[rom_ad];
    rom_data <= rom_r1;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Requester side: command queues and the currently presented command.
  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
    int                gap;
  } cmd_t;
  cmd_t cq0[$];
  cmd_t cq1[$];
  logic              drv_valid [2];
  logic [ADDR_W-1:0] drv_addr  [2];
  logic [LEN_W-1:0]  drv_len   [2];
  int                wait_cnt  [2];

  assign req0_valid = drv_valid[0];
  assign req0_addr  = drv_addr[0];
  assign req0_len   = drv_len[0];
  assign req1_valid = drv_valid[1];
  assign req1_addr  = drv_addr[1];
  assign req1_len   = drv_len[1];

  // Reference model: beats left in the current burst, its owner and next
  // address, who was served last, and a time-stamped list of expected beats.
  typedef struct {
    int                at_edge;
    logic              id;
    logic              last;
    logic [DATA_W-1:0] data;
  } exp_t;
  exp_t              exp_q[$];
  int                m_left;
  logic              m_owner, m_last_grant;
  logic [ADDR_W-1:0] m_addr, m_rom_ad;
  logic [DATA_W-1:0] m_data [2];
  int                edge_no;

  function automatic void model_clear();
    m_left       = 0;
    m_owner      = 1'b0;
    m_last_grant = 1'b1;
    m_addr       = '0;
    m_rom_ad     = '0;
    m_data[0]    = '0;
    m_data[1]    = '0;
    exp_q.delete();
  endfunction

  task automatic push_cmd(input int r, input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] l, input int g);
    cmd_t c;
    c.addr = a; c.len = l; c.gap = g;
    if (r == 0) cq0.push_back(c); else cq1.push_back(c);
  endtask

  // Present the next queued command once the requester is free and its gap elapsed.
  task automatic drive_update();
    for (int r = 0; r < 2; r++) begin
      if (!drv_valid[r] && ((r == 0) ? cq0.size() : cq1.size()) > 0) begin
        cmd_t c;
        c = (r == 0) ? cq0[0] : cq1[0];
        if (wait_cnt[r] >= c.gap) begin
          if (r == 0) void'(cq0.pop_front()); else void'(cq1.pop_front());
          drv_valid[r] = 1'b1;
          drv_addr[r]  = c.addr;
          drv_len[r]   = c.len;
          wait_cnt[r]  = 0;
        end else begin
          wait_cnt[r]++;
        end
      end
    end
  endtask

  // One model step per clock edge, then compare every DUT output.
  task automatic step();
    logic       exp_rdy [2];
    logic       exp_v   [2];
    logic       exp_l   [2];
    logic       g;
    logic       granted;
    exp_t       e;
    edge_no++;
    exp_rdy[0] = 1'b0; exp_rdy[1] = 1'b0;
    exp_v[0]   = 1'b0; exp_v[1]   = 1'b0;
    exp_l[0]   = 1'b0; exp_l[1]   = 1'b0;
    granted    = 1'b0;
    g          = 1'b0;
    if (m_left == 0) begin
      if (drv_valid[0] || drv_valid[1]) begin
        g = (drv_valid[0] && drv_valid[1]) ? !m_last_grant : drv_valid[1];
        granted      = 1'b1;
        exp_rdy[g]   = 1'b1;
        m_last_grant = g;
        m_owner      = g;
        m_addr       = drv_addr[g];
        m_left       = int'(drv_len[g]) + 1;
      end
    end else begin
      m_rom_ad  = m_addr;
      e.at_edge = edge_no + 3;
      e.id      = m_owner;
      e.last    = (m_left == 1);
      e.data    = rom_mem[m_addr];
      exp_q.push_back(e);
      m_addr    = m_addr + 1'b1;
      m_left--;
    end
    if (exp_q.size() > 0 && exp_q[0].at_edge == edge_no) begin
      e = exp_q.pop_front();
      exp_v[e.id] = 1'b1;
      exp_l[e.id] = e.last;
      m_data[e.id] = e.data;
    end
    check_eq("req0_ready", req0_ready, exp_rdy[0]);
    check_eq("req1_ready", req1_ready, exp_rdy[1]);
    check_eq("rom_ad", rom_ad, m_rom_ad);
    check_eq("rsp0_valid", rsp0_valid, exp_v[0]);
    check_eq("rsp1_valid", rsp1_valid, exp_v[1]);
    check_eq("rsp0_last", rsp0_last, exp_l[0]);
    check_eq("rsp1_last", rsp1_last, exp_l[1]);
    check_eq("rsp0_data", rsp0_data, m_data[0]);
    check_eq("rsp1_data", rsp1_data, m_data[1]);
    check_eq("busy", busy, (m_left > 0) || (exp_q.size() > 0));
    check_eq("rsp_exclusive", rsp0_valid & rsp1_valid, 1'b0);
    if (granted) drv_valid[g] = 1'b0;
    drive_update();
  endtask

  task automatic run_cycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      step();
    end
  endtask

  task automatic drain();
    int k = 0;
    while ((cq0.size() > 0 || cq1.size() > 0 || drv_valid[0] || drv_valid[1] ||
            m_left > 0 || exp_q.size() > 0) && k < 2000) begin
      run_cycles(1);
      k++;
    end
    check_eq("drain_timeout", (k >= 2000), 1'b0);
    run_cycles(2);
  endtask

  // Assert reset between edges, verify the asynchronous clear, release later.
  task automatic do_reset();
    reset = 1'b1;
    #1;
    check_eq("rst_req0_ready", req0_ready, 1'b0);
    check_eq("rst_req1_ready", req1_ready, 1'b0);
    check_eq("rst_rsp0_valid", rsp0_valid, 1'b0);
    check_eq("rst_rsp1_valid", rsp1_valid, 1'b0);
    check_eq("rst_rsp0_last", rsp0_last, 1'b0);
    check_eq("rst_rsp1_last", rsp1_last, 1'b0);
    check_eq("rst_rsp0_data", rsp0_data, '0);
    check_eq("rst_rsp1_data", rsp1_data, '0);
    check_eq("rst_rom_ad", rom_ad, '0);
    check_eq("rst_busy", busy, 1'b0);
    model_clear();
    cq0.delete();
    cq1.delete();
    for (int r = 0; r < 2; r++) begin
      drv_valid[r] = 1'b0; drv_addr[r] = '0; drv_len[r] = '0; wait_cnt[r] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    int guard;
    for (int i = 0; i < 2048; i++) rom_mem[i] = DATA_W'($urandom);
    edge_no = 0;
    #2;
    do_reset();

    // Single burst from requester 0.
    push_cmd(0, 11'h010, 4'd3, 0);
    drive_update();
    drain();

    // Contention from reset: both requesters keep asking.
    do_reset();
    push_cmd(0, 11'h100, 4'd1, 0);
    push_cmd(0, 11'h104, 4'd1, 0);
    push_cmd(1, 11'h200, 4'd2, 0);
    push_cmd(1, 11'h208, 4'd2, 0);
    drive_update();
    drain();

    // Address wrap across the top of the ROM.
    push_cmd(1, 11'h7FE, 4'd3, 0);
    drive_update();
    drain();

    // Single-word reads at scattered addresses, both banks.
    for (int i = 0; i < 6; i++) push_cmd(0, ADDR_W'($urandom), 4'd0, i % 3);
    drive_update();
    drain();

    // Reset during the second beat of a long burst, then contention again.
    push_cmd(0, 11'h300, 4'd7, 0);
    drive_update();
    guard = 0;
    while (m_left != 6 && guard < 50) begin
      run_cycles(1);
      guard++;
    end
    check_eq("reach_beat2", (m_left == 6), 1'b1);
    do_reset();
    push_cmd(0, 11'h500, 4'd2, 0);
    push_cmd(1, 11'h600, 4'd2, 0);
    drive_update();
    drain();

    // Requester 0 keeps asking for full bursts; requester 1 asks once.
    for (int i = 0; i < 3; i++) push_cmd(0, ADDR_W'($urandom), 4'd15, 0);
    drive_update();
    run_cycles(5);
    push_cmd(1, 11'h400, 4'd2, 0);
    drain();

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        int r;
        r = $urandom_range(0, 1);
        if (((r == 0) ? cq0.size() : cq1.size()) < 3)
          push_cmd(r, ADDR_W'($urandom), LEN_W'($urandom), $urandom_range(0, 3));
      end
      run_cycles(1);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
